tail_light_seq: RTL and testbench



---
 rtl/tail_light_pkg.sv | 28 ++
 rtl/step_prescaler.sv | 41 ++++
 rtl/tail_light_seq.sv | 148 ++++++++++++++
 tb/tb_tail_light_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the tail-light sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tail_light_pkg;

    // Sequencer states. HAZ covers both the hazard input and left+right together.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } state_e;

    // Widest lamp bank the sequencer supports.
    localparam int MAX_LAMPS = 16;

    // Cumulative inside-out sweep: step k < lamps lights bits [k:0].
    // Step == lamps is the dark step, so the mask is all zero.
    function automatic logic [MAX_LAMPS-1:0] sweep_mask(input int step, input int lamps);
        logic [MAX_LAMPS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LAMPS; i++) begin
            m[i] = (i <= step) && (step < lamps);
        end
        return m;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-period prescaler: pulses tick once every DIV enabled cycles.
// Latency: tick is combinational from the count register; clear takes effect next cycle.
// Backpressure: none; counting is gated only by en, and clear overrides en.
// Ports: clk, reset (sync, active-high), clear (restart count at 0),
//        en (count this cycle), tick (last cycle of the current period).
module step_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    // DIV=1 would give a zero-width counter; keep one bit that simply stays 0.
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tail_light_seq.sv
// Tail-light sequencer: cumulative turn sweep per side, hazard flash, brake overlay.
// Latency: 1 clock from any input (requests and brake) to the lamp outputs.
// Backpressure: none; level inputs are sampled every cycle.
// Ports: clk, reset (sync, active-high); left/right/hazard/brake level requests;
//        l_lamps/r_lamps (bit 0 innermost); busy (sequencer not idle).
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS = 3,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] l_lamps,
    output logic [LAMPS-1:0] r_lamps,
    output logic             busy
);

    localparam int               SW     = $clog2(LAMPS + 1);
    localparam logic [SW-1:0]    DARK   = SW'(LAMPS);
    localparam logic [LAMPS-1:0] ALL_ON = '1;

    state_e           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic             brake_q;
    logic             tick;
    logic             presc_clear;
    logic             presc_en;
    logic [LAMPS-1:0] sweep;
    logic [LAMPS-1:0] brake_pat;
    logic [LAMPS-1:0] haz_pat;

    // Every state change restarts the period, so a new pattern is always held
    // for a full DIV cycles. LEFT->LEFT restarts wrap the counter naturally.
    assign presc_en    = (state_q != IDLE);
    assign presc_clear = (state_d != state_q);

    step_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .en    (presc_en),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            brake_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            brake_q <= brake;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                step_d = '0;
                if (hazard || (left && right)) begin
                    state_d = HAZ;
                end else if (left) begin
                    state_d = LEFT;
                end else if (right) begin
                    state_d = RIGHT;
                end
            end
            LEFT, RIGHT: begin
                // Only hazard interrupts a sweep; direction changes wait for the
                // dark step and are then picked up again from IDLE.
                if (hazard) begin
                    state_d = HAZ;
                    step_d  = '0;
                end else if (tick) begin
                    if (step_q == DARK) begin
                        step_d = '0;
                        if (!((state_q == LEFT) ? left : right)) begin
                            state_d = IDLE;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            HAZ: begin
                // Step 0 is the ON phase, step 1 the OFF phase; exit only after OFF.
                if (tick) begin
                    if (step_q != '0) begin
                        step_d = '0;
                        if (!(hazard || (left && right))) begin
                            state_d = IDLE;
                        end
                    end else begin
                        step_d = SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Outputs decode registered state only, so inputs never reach lamps combinationally.
    always_comb begin
        sweep     = LAMPS'(sweep_mask(int'(step_q), LAMPS));
        brake_pat = brake_q ? ALL_ON : '0;
        haz_pat   = (step_q == '0) ? ALL_ON : '0;
        l_lamps   = '0;
        r_lamps   = '0;
        case (state_q)
            IDLE: begin
                l_lamps = brake_pat;
                r_lamps = brake_pat;
            end
            LEFT: begin
                l_lamps = sweep;
                r_lamps = brake_pat;
            end
            RIGHT: begin
                l_lamps = brake_pat;
                r_lamps = sweep;
            end
            HAZ: begin
                l_lamps = haz_pat;
                r_lamps = haz_pat;
            end
            default: begin
                l_lamps = '0;
                r_lamps = '0;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq: one instance at LAMPS=3/DIV=2, one at LAMPS=5/DIV=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tail_light_seq;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       left   = 1'b0;
    logic       right  = 1'b0;
    logic       hazard = 1'b0;
    logic       brake  = 1'b0;
    logic [2:0] l_lamps, r_lamps;
    logic       busy;

    logic       b_left   = 1'b0;
    logic       b_right  = 1'b0;
    logic       b_hazard = 1'b0;
    logic       b_brake  = 1'b0;
    logic [4:0] b_l, b_r;
    logic       b_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] sw3 [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    logic [4:0] sw5 [6] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000};

    tail_light_seq #(.LAMPS(3), .DIV(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .left    (left),
        .right   (right),
        .hazard  (hazard),
        .brake   (brake),
        .l_lamps (l_lamps),
        .r_lamps (r_lamps),
        .busy    (busy)
    );

    tail_light_seq #(.LAMPS(5), .DIV(1)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .left    (b_left),
        .right   (b_right),
        .hazard  (b_hazard),
        .brake   (b_brake),
        .l_lamps (b_l),
        .r_lamps (b_r),
        .busy    (b_busy)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] el, input logic [2:0] er, input logic eb);
        chk({tag, ".l"}, 32'(l_lamps), 32'(el));
        chk({tag, ".r"}, 32'(r_lamps), 32'(er));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    initial begin
        logic [2:0] hp;

        // Reset state
        cyc(2);
        reset = 1'b0;
        chk_a("rst", 3'b000, 3'b000, 1'b0);
        chk("rst.b_busy", 32'(b_busy), 32'd0);

        // Reset held two cycles in the middle of a LEFT sweep
        left = 1'b1;
        cyc(1);
        chk_a("mid.s0", 3'b001, 3'b000, 1'b1);
        left = 1'b0;
        cyc(2);
        chk_a("mid.s1", 3'b011, 3'b000, 1'b1);
        reset = 1'b1;
        cyc(1);
        chk_a("mid.rst1", 3'b000, 3'b000, 1'b0);
        cyc(1);
        reset = 1'b0;
        chk_a("mid.rst2", 3'b000, 3'b000, 1'b0);

        // One-cycle left pulse: full sweep, each pattern for 2 cycles
        left = 1'b1;
        cyc(1);
        left = 1'b0;
        for (int j = 0; j < 8; j++) begin
            chk_a($sformatf("sweep%0d", j), sw3[j/2], 3'b000, 1'b1);
            cyc(1);
        end
        chk_a("sweep.end", 3'b000, 3'b000, 1'b0);

        // Left held 20 cycles with brake: repeating sweep, right side braked
        left  = 1'b1;
        brake = 1'b1;
        for (int j = 0; j < 20; j++) begin
            cyc(1);
            chk_a($sformatf("hold%0d", j), sw3[(j/2)%4], 3'b111, 1'b1);
        end
        left = 1'b0;
        for (int j = 20; j < 24; j++) begin
            cyc(1);
            chk_a($sformatf("tail%0d", j), sw3[(j/2)%4], 3'b111, 1'b1);
        end
        cyc(1);
        chk_a("hold.idlebrake", 3'b111, 3'b111, 1'b0);
        brake = 1'b0;
        cyc(1);
        chk_a("hold.idle", 3'b000, 3'b000, 1'b0);

        // Hazard preempts a LEFT sweep at pattern 011
        left = 1'b1;
        cyc(1);
        left = 1'b0;
        cyc(2);
        chk_a("pre.011", 3'b011, 3'b000, 1'b1);
        hazard = 1'b1;
        cyc(1);
        chk_a("haz.on0", 3'b111, 3'b111, 1'b1);
        cyc(1);
        chk_a("haz.on1", 3'b111, 3'b111, 1'b1);
        hazard = 1'b0;
        cyc(1);
        chk_a("haz.off0", 3'b000, 3'b000, 1'b1);
        cyc(1);
        chk_a("haz.off1", 3'b000, 3'b000, 1'b1);
        cyc(1);
        chk_a("haz.idle", 3'b000, 3'b000, 1'b0);

        // left && right acts as hazard; brake ignored
        left  = 1'b1;
        right = 1'b1;
        brake = 1'b1;
        for (int j = 0; j < 8; j++) begin
            cyc(1);
            hp = (((j/2) % 2) == 0) ? 3'b111 : 3'b000;
            chk_a($sformatf("lr%0d", j), hp, hp, 1'b1);
        end
        left  = 1'b0;
        right = 1'b0;
        brake = 1'b0;
        cyc(1);
        chk_a("lr.idle", 3'b000, 3'b000, 1'b0);

        // Opposite request mid-sweep waits for the sweep to finish
        left = 1'b1;
        cyc(1);
        left  = 1'b0;
        right = 1'b1;
        for (int j = 0; j < 8; j++) begin
            chk_a($sformatf("opp%0d", j), sw3[j/2], 3'b000, 1'b1);
            cyc(1);
        end
        chk_a("opp.gap", 3'b000, 3'b000, 1'b0);
        cyc(1);
        chk_a("opp.right", 3'b000, 3'b001, 1'b1);
        right = 1'b0;
        cyc(8);
        chk_a("opp.done", 3'b000, 3'b000, 1'b0);

        // LAMPS=5, DIV=1: pattern changes every cycle, 6-cycle sweep
        b_right = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cyc(1);
            chk($sformatf("b.r%0d", j), 32'(b_r), 32'(sw5[j%6]));
            chk($sformatf("b.l%0d", j), 32'(b_l), 32'd0);
            chk($sformatf("b.busy%0d", j), 32'(b_busy), 32'd1);
        end
        b_right = 1'b0;
        cyc(1);
        chk("b.idle.r", 32'(b_r), 32'd0);
        chk("b.idle.busy", 32'(b_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
